// File: rtl/ctrl_pipe_decoder.sv
// rtl/ctrl_pipe_decoder.sv - pipelined main decoder with ID/EX, EX/MEM, MEM/WB control registers
module ctrl_pipe_decoder #(
  parameter bit EXT_EN   = 1'b1,
  parameter int IMMSRC_W = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          op_d,
  input  logic                valid_d,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic                cnt_clr,
  output logic [IMMSRC_W-1:0] imm_src_d,
  output logic                illegal_d,
  output logic                reg_write_e,
  output logic                mem_write_e,
  output logic                branch_e,
  output logic                jump_e,
  output logic                jump_reg_e,
  output logic                alu_src_e,
  output logic [1:0]          result_src_e,
  output logic [1:0]          alu_op_e,
  output logic                valid_e,
  output logic                illegal_e,
  output logic                reg_write_m,
  output logic                mem_write_m,
  output logic [1:0]          result_src_m,
  output logic                reg_write_w,
  output logic [1:0]          result_src_w,
  output logic [CNT_W-1:0]    illegal_cnt
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       valid;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_t;

  ctl_t                dec;
  logic [IMMSRC_W-1:0] imm_dec;
  logic                known;

  ctl_t             ex_d, ex_q;
  mem_t             mem_d, mem_q;
  wb_t              wb_d, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Opcode decode; bubbles and unknown opcodes collapse to an all-zero bundle
  always_comb begin
    dec     = '0;
    imm_dec = '0;
    known   = 1'b1;
    case (op_d)
      7'b0000011: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01;
      end
      7'b0100011: begin
        imm_dec = IMMSRC_W'(3'b001); dec.alu_src = 1'b1; dec.mem_write = 1'b1;
      end
      7'b0110011: begin
        dec.reg_write = 1'b1; dec.alu_op = 2'b10;
      end
      7'b1100011: begin
        imm_dec = IMMSRC_W'(3'b010); dec.branch = 1'b1; dec.alu_op = 2'b01;
      end
      7'b0010011: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10;
      end
      7'b1101111: begin
        dec.reg_write = 1'b1; imm_dec = IMMSRC_W'(3'b011);
        dec.result_src = 2'b10; dec.jump = 1'b1;
      end
      7'b0110111: begin
        if (EXT_EN) begin
          dec.reg_write = 1'b1; imm_dec = IMMSRC_W'(3'b100);
          dec.alu_src = 1'b1; dec.result_src = 2'b11;
        end else begin
          known = 1'b0;
        end
      end
      7'b1100111: begin
        if (EXT_EN) begin
          dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b10;
          dec.jump = 1'b1; dec.jump_reg = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      default: known = 1'b0;
    endcase
    if (!valid_d || !known) begin
      dec     = '0;
      imm_dec = '0;
    end
    dec.valid   = valid_d;
    dec.illegal = valid_d & ~known;
  end

  // Next-state for the three pipeline registers and the illegal counter
  always_comb begin
    ex_d  = ex_q;
    mem_d = '0;
    wb_d  = '0;
    cnt_d = cnt_q;
    if (flush_e) begin
      ex_d = '0;
    end else if (!stall_e) begin
      ex_d = dec;
    end
    if (!(stall_e && !flush_e)) begin
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.result_src = ex_q.result_src;
    end
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.result_src = mem_q.result_src;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (dec.illegal && !flush_e && !stall_e && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset turns every stage into a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign imm_src_d    = imm_dec;
  assign illegal_d    = dec.illegal;
  assign reg_write_e  = ex_q.reg_write;
  assign mem_write_e  = ex_q.mem_write;
  assign branch_e     = ex_q.branch;
  assign jump_e       = ex_q.jump;
  assign jump_reg_e   = ex_q.jump_reg;
  assign alu_src_e    = ex_q.alu_src;
  assign result_src_e = ex_q.result_src;
  assign alu_op_e     = ex_q.alu_op;
  assign valid_e      = ex_q.valid;
  assign illegal_e    = ex_q.illegal;
  assign reg_write_m  = mem_q.reg_write;
  assign mem_write_m  = mem_q.mem_write;
  assign result_src_m = mem_q.result_src;
  assign reg_write_w  = wb_q.reg_write;
  assign result_src_w = wb_q.result_src;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// tb/tb_ctrl_pipe_decoder.sv - scoreboard bench for ctrl_pipe_decoder (EXT_EN=1/CNT_W=8 and EXT_EN=0/CNT_W=2)
module tb_ctrl_pipe_decoder;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // row: [12] rw, [11:9] imm, [8] alu_src, [7] mw, [6:5] rs, [4] br, [3:2] alu_op, [1] j, [0] jr
  typedef struct packed {
    logic [12:0] e_row;
    logic        e_v;
    logic        e_il;
    logic        m_rw;
    logic        m_mw;
    logic [1:0]  m_rs;
    logic        w_rw;
    logic [1:0]  w_rs;
    logic [7:0]  cnt;
  } m_t;

  logic       clk = 1'b0;
  logic       rst_n, valid_d, stall_e, flush_e, cnt_clr;
  logic [6:0] op_d;

  logic [2:0] imm1, imm0;
  logic       il1, il0;
  logic       rw_e1, mw_e1, br_e1, j_e1, jr_e1, as_e1, v_e1, ile1;
  logic       rw_e0, mw_e0, br_e0, j_e0, jr_e0, as_e0, v_e0, ile0;
  logic [1:0] rs_e1, aop_e1, rs_e0, aop_e0;
  logic       rw_m1, mw_m1, rw_w1, rw_m0, mw_m0, rw_w0;
  logic [1:0] rs_m1, rs_w1, rs_m0, rs_w0;
  logic [7:0] cnt1;
  logic [1:0] cnt0;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  m_t st1, st0;
  m_t q1[$];
  m_t q0[$];

  always #5 clk = ~clk;

  ctrl_pipe_decoder #(.EXT_EN(1'b1), .IMMSRC_W(3), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .cnt_clr(cnt_clr), .imm_src_d(imm1), .illegal_d(il1),
    .reg_write_e(rw_e1), .mem_write_e(mw_e1), .branch_e(br_e1), .jump_e(j_e1),
    .jump_reg_e(jr_e1), .alu_src_e(as_e1), .result_src_e(rs_e1), .alu_op_e(aop_e1),
    .valid_e(v_e1), .illegal_e(ile1), .reg_write_m(rw_m1), .mem_write_m(mw_m1),
    .result_src_m(rs_m1), .reg_write_w(rw_w1), .result_src_w(rs_w1), .illegal_cnt(cnt1)
  );

  ctrl_pipe_decoder #(.EXT_EN(1'b0), .IMMSRC_W(3), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .cnt_clr(cnt_clr), .imm_src_d(imm0), .illegal_d(il0),
    .reg_write_e(rw_e0), .mem_write_e(mw_e0), .branch_e(br_e0), .jump_e(j_e0),
    .jump_reg_e(jr_e0), .alu_src_e(as_e0), .result_src_e(rs_e0), .alu_op_e(aop_e0),
    .valid_e(v_e0), .illegal_e(ile0), .reg_write_m(rw_m0), .mem_write_m(mw_m0),
    .result_src_m(rs_m0), .reg_write_w(rw_w0), .result_src_w(rs_w0), .illegal_cnt(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic logic [12:0] tbl(input logic [6:0] op, input bit ext);
    case (op)
      OP_LW:   return 13'b1_000_1_0_01_0_00_0_0;
      OP_SW:   return 13'b0_001_1_1_00_0_00_0_0;
      OP_R:    return 13'b1_000_0_0_00_0_10_0_0;
      OP_BEQ:  return 13'b0_010_0_0_00_1_01_0_0;
      OP_I:    return 13'b1_000_1_0_00_0_10_0_0;
      OP_JAL:  return 13'b1_011_0_0_10_0_00_1_0;
      OP_LUI:  return ext ? 13'b1_100_1_0_11_0_00_0_0 : 13'b0;
      OP_JALR: return ext ? 13'b1_000_1_0_10_0_00_1_1 : 13'b0;
      default: return 13'b0;
    endcase
  endfunction

  function automatic bit known(input logic [6:0] op, input bit ext);
    case (op)
      OP_LW, OP_SW, OP_R, OP_BEQ, OP_I, OP_JAL: return 1'b1;
      OP_LUI, OP_JALR: return ext;
      default: return 1'b0;
    endcase
  endfunction

  function automatic m_t step(input m_t s, input logic [6:0] op, input logic v, input logic st,
                              input logic fl, input logic clr, input bit ext, input int cmax);
    m_t n;
    logic [12:0] row;
    logic il;
    row = v ? tbl(op, ext) : 13'b0;
    row[11:9] = 3'b000;
    il = v && !known(op, ext);
    n = s;
    n.w_rw = s.m_rw;
    n.w_rs = s.m_rs;
    if (st && !fl) begin
      n.m_rw = 1'b0; n.m_mw = 1'b0; n.m_rs = 2'b00;
    end else begin
      n.m_rw = s.e_row[12]; n.m_mw = s.e_row[7]; n.m_rs = s.e_row[6:5];
    end
    if (fl) begin
      n.e_row = '0; n.e_v = 1'b0; n.e_il = 1'b0;
    end else if (!st) begin
      n.e_row = row; n.e_v = v; n.e_il = il;
    end
    if (clr) n.cnt = 8'd0;
    else if (il && !fl && !st && (int'(s.cnt) < cmax)) n.cnt = s.cnt + 8'd1;
    return n;
  endfunction

  task automatic cmp(input string inst, input m_t got, input m_t exp);
    chk({inst, ".ex_bundle"}, 32'(got.e_row), 32'(exp.e_row));
    chk({inst, ".valid_e"}, 32'(got.e_v), 32'(exp.e_v));
    chk({inst, ".illegal_e"}, 32'(got.e_il), 32'(exp.e_il));
    chk({inst, ".mem_stage"}, 32'({got.m_rw, got.m_mw, got.m_rs}), 32'({exp.m_rw, exp.m_mw, exp.m_rs}));
    chk({inst, ".wb_stage"}, 32'({got.w_rw, got.w_rs}), 32'({exp.w_rw, exp.w_rs}));
    chk({inst, ".illegal_cnt"}, 32'(got.cnt), 32'(exp.cnt));
  endtask

  task automatic cyc(input logic [6:0] op, input logic v, input logic st, input logic fl,
                     input logic clr, input logic rst);
    m_t o1, o0, e1, e0;
    logic [12:0] r1, r0;
    @(negedge clk);
    op_d = op; valid_d = v; stall_e = st; flush_e = fl; cnt_clr = clr; rst_n = ~rst;
    #1;
    r1 = tbl(op, 1'b1);
    r0 = tbl(op, 1'b0);
    chk("d1.imm_src_d", 32'(imm1), v ? 32'(r1[11:9]) : 32'd0);
    chk("d0.imm_src_d", 32'(imm0), v ? 32'(r0[11:9]) : 32'd0);
    chk("d1.illegal_d", 32'(il1), 32'(v && !known(op, 1'b1)));
    chk("d0.illegal_d", 32'(il0), 32'(v && !known(op, 1'b0)));
    if (rst) begin
      st1 = '0; st0 = '0;
    end else begin
      st1 = step(st1, op, v, st, fl, clr, 1'b1, 255);
      st0 = step(st0, op, v, st, fl, clr, 1'b0, 3);
    end
    q1.push_back(st1);
    q0.push_back(st0);
    @(posedge clk);
    #1;
    cyc_n++;
    o1 = '{e_row: {rw_e1, 3'b000, as_e1, mw_e1, rs_e1, br_e1, aop_e1, j_e1, jr_e1},
           e_v: v_e1, e_il: ile1, m_rw: rw_m1, m_mw: mw_m1, m_rs: rs_m1,
           w_rw: rw_w1, w_rs: rs_w1, cnt: cnt1};
    o0 = '{e_row: {rw_e0, 3'b000, as_e0, mw_e0, rs_e0, br_e0, aop_e0, j_e0, jr_e0},
           e_v: v_e0, e_il: ile0, m_rw: rw_m0, m_mw: mw_m0, m_rs: rs_m0,
           w_rw: rw_w0, w_rs: rs_w0, cnt: {6'b0, cnt0}};
    if (q1.size() == 0 || q0.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      cmp("d1", o1, e1);
      cmp("d0", o0, e0);
    end
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_I, OP_JAL, OP_LUI, OP_JALR, 7'b1111111, 7'b0000000};
    st1 = '0; st0 = '0;
    rst_n = 1'b0; op_d = OP_LW; valid_d = 1'b1; stall_e = 1'b0; flush_e = 1'b0; cnt_clr = 1'b0;

    // reset held two cycles with a live lw on the decode inputs
    cyc(OP_LW, 1, 0, 0, 0, 1);
    cyc(OP_LW, 1, 0, 0, 0, 1);
    chk("reset_cnt1", 32'(cnt1), 32'd0);
    chk("reset_rw_w1", 32'(rw_w1), 32'd0);
    // release: lw reaches EX, then a bubble trails so lw is traced to WB
    cyc(OP_LW, 1, 0, 0, 0, 0);
    chk("lw_rs_e", 32'(rs_e1), 32'd1);
    cyc(OP_LW, 0, 0, 0, 0, 0);
    cyc(OP_LW, 0, 0, 0, 0, 0);
    chk("lw_rw_w", 32'(rw_w1), 32'd1);
    chk("lw_rs_w", 32'(rs_w1), 32'd1);

    // back-to-back sweep of every decoded opcode
    for (int i = 0; i < 8; i++) cyc(ops[i], 1, 0, 0, 0, 0);
    cyc(OP_R, 0, 0, 0, 0, 0);
    cyc(OP_R, 0, 0, 0, 0, 0);

    // stall twice with R-type in EX, then flush together with stall
    cyc(OP_R, 1, 0, 0, 0, 0);
    cyc(OP_SW, 1, 1, 0, 0, 0);
    cyc(OP_SW, 1, 1, 0, 0, 0);
    chk("stall_rw_e_held", 32'(rw_e1), 32'd1);
    chk("stall_rw_m_zero", 32'(rw_m1), 32'd0);
    cyc(OP_SW, 1, 1, 1, 0, 0);
    chk("flush_valid_e", 32'(v_e1), 32'd0);

    // illegal lui on the EXT_EN=0 instance, loaded then flushed
    cyc(OP_LUI, 1, 0, 0, 1, 0);
    cyc(OP_LUI, 1, 0, 0, 0, 0);
    chk("ill_e0", 32'(ile0), 32'd1);
    chk("ill_cnt0", 32'(cnt0), 32'd1);
    cyc(OP_LUI, 1, 0, 1, 0, 0);
    chk("ill_flush_cnt0", 32'(cnt0), 32'd1);

    // saturation of the 2-bit counter, then clear beating an increment
    cyc(OP_R, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(OP_LUI, 1, 0, 0, 0, 0);
    chk("sat_cnt0", 32'(cnt0), 32'd3);
    cyc(OP_LUI, 1, 0, 0, 1, 0);
    chk("clr_cnt0", 32'(cnt0), 32'd0);

    // invalid sw is a bubble
    cyc(OP_SW, 0, 0, 0, 0, 0);
    chk("inv_mw_e", 32'(mw_e1), 32'd0);

    // random mix including a mid-stream reset
    for (int i = 0; i < 60; i++) begin
      cyc(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 15) == 0), 1'(i == 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
